// File: rtl/tow_led_pkg.sv
// Shared mode encodings and small types for the tug-of-war LED bar controller.
package tow_led_pkg;

    localparam int unsigned MODE_W = 3;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t LED_DARK  = 3'b000;
    localparam mode_t LED_SCORE = 3'b001;
    localparam mode_t LED_ALL   = 3'b010;
    localparam mode_t LED_BLINK = 3'b011;
    localparam mode_t LED_CHASE = 3'b100;
    localparam mode_t LED_DIM   = 3'b101;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_e;

endpackage

// File: rtl/led_pattern_ctrl_if.sv
// Mode/score/duty inputs and LED/tick outputs between the game FSM and the LED driver.
interface led_pattern_ctrl_if #(
    parameter int unsigned N_LEDS   = 7,
    parameter int unsigned PWM_BITS = 4
);
    import tow_led_pkg::*;

    mode_t               led_ctrl;
    logic [N_LEDS-1:0]   score;
    logic [PWM_BITS-1:0] duty;
    logic [N_LEDS-1:0]   led_out;
    logic                tick;

    modport master (
        output led_ctrl, score, duty,
        input  led_out, tick
    );

    modport slave (
        input  led_ctrl, score, duty,
        output led_out, tick
    );

endinterface

// File: rtl/led_prescaler.sv
// Animation prescaler: counts 0..CLK_DIV-1 and emits a registered one-cycle tick after each wrap.
module led_prescaler #(
    parameter int unsigned CLK_DIV = 2_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick,
    output logic wrap
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] presc_q, presc_d;
    logic          tick_q;

    // wrap is the same-cycle strobe, so the parent can advance animation state on the tick edge
    assign wrap = (presc_q == CW'(CLK_DIV - 1));
    assign tick = tick_q;

    always_comb begin
        presc_d = presc_q + 1'b1;
        if (clr || wrap) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= wrap & ~clr;
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED score-bar driver: static, blink, bouncing chase and PWM-dimmed modes, registered output.
module led_pattern_ctrl
    import tow_led_pkg::*;
#(
    parameter int unsigned N_LEDS   = 7,
    parameter int unsigned CLK_DIV  = 2_500_000,
    parameter int unsigned PWM_BITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    led_pattern_ctrl_if.slave  bus
);

    localparam int unsigned POS_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

    mode_t               prev_mode_q;
    logic                phase_q, phase_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    dir_e                dir_q, dir_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [N_LEDS-1:0]   led_q, led_d;
    logic                change;
    logic                wrap;
    logic                tick;

    assign change = (bus.led_ctrl != prev_mode_q);

    led_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (change),
        .tick (tick),
        .wrap (wrap)
    );

    always_comb begin
        phase_d   = phase_q;
        pos_d     = pos_q;
        dir_d     = dir_q;
        pwm_cnt_d = pwm_cnt_q + 1'b1;

        if (change) begin
            phase_d = 1'b1;
            pos_d   = '0;
            dir_d   = DIR_UP;
        end else if (wrap) begin
            phase_d = ~phase_q;
            if (N_LEDS > 1) begin
                if (dir_q == DIR_UP) begin
                    if (pos_q == POS_W'(N_LEDS - 1)) begin
                        pos_d = POS_W'(N_LEDS - 2);
                        dir_d = DIR_DOWN;
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                end else begin
                    if (pos_q == '0) begin
                        pos_d = POS_W'(1);
                        dir_d = DIR_UP;
                    end else begin
                        pos_d = pos_q - 1'b1;
                    end
                end
            end
        end

        // output is built from next-state values so a mode entry shows on the same edge
        led_d = '0;
        case (bus.led_ctrl)
            LED_DARK:  led_d = '0;
            LED_SCORE: led_d = bus.score;
            LED_ALL:   led_d = '1;
            LED_BLINK: led_d = phase_d ? bus.score : '0;
            LED_CHASE: led_d = N_LEDS'(1) << pos_d;
            LED_DIM:   led_d = (pwm_cnt_d < bus.duty) ? bus.score : '0;
            default:   led_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_mode_q <= LED_DARK;
            phase_q     <= 1'b1;
            pos_q       <= '0;
            dir_q       <= DIR_UP;
            pwm_cnt_q   <= '0;
            led_q       <= '0;
        end else begin
            prev_mode_q <= bus.led_ctrl;
            phase_q     <= phase_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            pwm_cnt_q   <= pwm_cnt_d;
            led_q       <= led_d;
        end
    end

    assign bus.led_out = led_q;
    assign bus.tick    = tick;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed + randomized bench for led_pattern_ctrl against a closed-form timing model.
module tb_led_pattern_ctrl;

    localparam int unsigned N   = 7;
    localparam int unsigned DIV = 4;
    localparam int unsigned PB  = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    led_pattern_ctrl_if #(.N_LEDS(N), .PWM_BITS(PB)) bus ();

    led_pattern_ctrl #(
        .N_LEDS   (N),
        .CLK_DIV  (DIV),
        .PWM_BITS (PB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Model: edges since last restart (reset or mode change) and edges since reset.
    int unsigned m_t;
    int unsigned m_g;
    logic [2:0]  m_prev;
    logic [N-1:0] exp_led;
    logic         exp_tick;

    task automatic model_edge(input logic r, input logic [2:0] mode,
                              input logic [N-1:0] sc, input logic [PB-1:0] du);
        int unsigned n, m, pos, pwm;
        bit          phase;
        if (r) begin
            m_t = 0; m_g = 0; m_prev = 3'b000;
            exp_led = '0; exp_tick = 1'b0;
        end else begin
            m_g++;
            if (mode != m_prev) m_t = 0;
            else                m_t++;
            m_prev   = mode;
            n        = m_t / DIV;
            exp_tick = (m_t > 0) && (m_t % DIV == 0);
            phase    = (n % 2 == 0);
            m        = n % (2 * (N - 1));
            pos      = (m < N) ? m : 2 * (N - 1) - m;
            pwm      = m_g % (1 << PB);
            case (mode)
                3'b000:  exp_led = '0;
                3'b001:  exp_led = sc;
                3'b010:  exp_led = '1;
                3'b011:  exp_led = phase ? sc : '0;
                3'b100:  exp_led = N'(1) << pos;
                3'b101:  exp_led = (pwm < du) ? sc : '0;
                default: exp_led = '0;
            endcase
        end
    endtask

    task automatic cycle(input logic r, input logic [2:0] mode,
                         input logic [N-1:0] sc, input logic [PB-1:0] du);
        rst          = r;
        bus.led_ctrl = mode;
        bus.score    = sc;
        bus.duty     = du;
        @(posedge clk);
        model_edge(r, mode, sc, du);
        #1;
        tests++;
        assert (bus.led_out === exp_led) else begin
            fails++;
            $error("FAIL led_out mode=%b t=%0d got=%b exp=%b", mode, m_t, bus.led_out, exp_led);
        end
        tests++;
        assert (bus.tick === exp_tick) else begin
            fails++;
            $error("FAIL tick mode=%b t=%0d got=%b exp=%b", mode, m_t, bus.tick, exp_tick);
        end
    endtask

    task automatic chk(input string tag, input logic [N-1:0] exp);
        tests++;
        assert (bus.led_out === exp) else begin
            fails++;
            $error("FAIL %s got=%b exp=%b", tag, bus.led_out, exp);
        end
    endtask

    initial begin
        int unsigned lit;
        int unsigned hold;
        logic [2:0]   rmode;
        logic [N-1:0] rscore;
        logic [PB-1:0] rduty;

        rst = 1'b1;
        bus.led_ctrl = 3'b000;
        bus.score    = '0;
        bus.duty     = '0;

        // reset then ALL
        cycle(1'b1, 3'b010, 7'b0000000, 4'd0);
        cycle(1'b1, 3'b010, 7'b0000000, 4'd0);
        chk("reset_dark", 7'b0000000);
        cycle(1'b0, 3'b010, 7'b0000000, 4'd0);
        chk("all_after_release", 7'b1111111);

        // SCORE follows input with one cycle latency
        cycle(1'b0, 3'b001, 7'b1110000, 4'd0);
        chk("score_a", 7'b1110000);
        cycle(1'b0, 3'b001, 7'b0000011, 4'd0);
        chk("score_b", 7'b0000011);

        // BLINK: starts lit, 4 on / 4 off
        cycle(1'b0, 3'b011, 7'b0001111, 4'd0);
        chk("blink_entry", 7'b0001111);
        for (int i = 0; i < 4; i++) cycle(1'b0, 3'b011, 7'b0001111, 4'd0);
        chk("blink_off", 7'b0000000);
        for (int i = 0; i < 20; i++) cycle(1'b0, 3'b011, 7'b0001111, 4'd0);

        // CHASE full bounce, then restart after a mode excursion
        cycle(1'b0, 3'b100, 7'b0000000, 4'd0);
        chk("chase_entry", 7'b0000001);
        for (int i = 0; i < 55; i++) cycle(1'b0, 3'b100, 7'b0000000, 4'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 3'b001, 7'b0101010, 4'd0);
        cycle(1'b0, 3'b100, 7'b0000000, 4'd0);
        chk("chase_restart", 7'b0000001);

        // DIM: duty 4 lights exactly 4 of every 16 cycles; duty 0 never
        lit = 0;
        for (int i = 0; i < 32; i++) begin
            cycle(1'b0, 3'b101, 7'b1111111, 4'd4);
            if (bus.led_out === 7'b1111111) lit++;
        end
        tests++;
        assert (lit == 8) else begin
            fails++;
            $error("FAIL dim_duty4_count got=%0d exp=%0d", lit, 8);
        end
        lit = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 3'b101, 7'b1111111, 4'd0);
            if (bus.led_out !== 7'b0000000) lit++;
        end
        tests++;
        assert (lit == 0) else begin
            fails++;
            $error("FAIL dim_duty0_count got=%0d exp=%0d", lit, 0);
        end

        // reset in CHASE at bit 3, then reserved mode
        for (int i = 0; i < 13; i++) cycle(1'b0, 3'b100, 7'b0000000, 4'd0);
        chk("chase_bit3", 7'b0001000);
        cycle(1'b1, 3'b100, 7'b0000000, 4'd0);
        chk("chase_reset", 7'b0000000);
        cycle(1'b0, 3'b100, 7'b0000000, 4'd0);
        chk("chase_after_reset", 7'b0000001);
        for (int i = 0; i < 6; i++) cycle(1'b0, 3'b110, 7'b1111111, 4'd15);
        chk("reserved_110", 7'b0000000);

        // randomized modes, scores, duties and occasional resets
        for (int i = 0; i < 40; i++) begin
            rmode = 3'($urandom_range(0, 7));
            hold  = $urandom_range(1, 30);
            rduty = 4'($urandom);
            for (int j = 0; j < int'(hold); j++) begin
                rscore = ($urandom_range(0, 3) == 0) ? 7'($urandom) : rscore;
                if ($urandom_range(0, 5) == 0) rduty = 4'($urandom);
                cycle(($urandom_range(0, 60) == 0), rmode, rscore, rduty);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
